// File: rtl/sdram_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wb_bridge
// Description : Wishbone classic 16-bit slave driving the SDRAM controller's
//               request / accept / read-ready handshake, with timeout and
//               abort handling. Optional one-entry read cache is enabled by
//               defining SDRAM_BRIDGE_RCACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wb_bridge #(
    parameter int unsigned       ADDR_W  = 24,
    parameter logic [ADDR_W-1:0] BASE    = 24'h100000,
    parameter logic [ADDR_W-1:0] END     = 24'hffdfff,
    parameter int unsigned       TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [1:0]        wb_sel,
    input  logic [15:0]       wb_i_dat,
    output logic [15:0]       wb_o_dat,
    output logic              wb_ack,
    output logic              wb_err,
    output logic [ADDR_W-1:0] c_addr,
    output logic [1:0]        c_addr_sel,
    output logic [15:0]       c_data_in,
    output logic              c_read_req,
    output logic              c_write_req,
    input  logic              c_cack,
    input  logic              c_read_ready,
    input  logic [31:0]       c_data_out
);

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RWAIT = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic              r_ack;
    logic              r_err;
    logic              r_rreq;
    logic              r_wreq;
    logic [15:0]       r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_sel;
    logic [15:0]       r_wdata;

    logic              w_req;
    logic              w_in_range;
    logic              w_tmo;
    logic              w_unused_hi;

    assign w_req       = wb_cyc & wb_stb;
    assign w_in_range  = (wb_adr >= BASE) && (wb_adr <= END);
    assign w_tmo       = (r_cnt == c_TMO_LAST);
    assign w_unused_hi = ^c_data_out[31:16];

`ifdef SDRAM_BRIDGE_RCACHE_EN
    logic              r_cv;
    logic [ADDR_W-1:0] r_ca;
    logic [15:0]       r_cd;
    logic              w_hit;

    assign w_hit = r_cv && !wb_we && (r_ca == wb_adr);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rreq  <= 1'b0;
            r_wreq  <= 1'b0;
            r_rdata <= 16'd0;
            r_addr  <= '0;
            r_sel   <= 2'd0;
            r_wdata <= 16'd0;
`ifdef SDRAM_BRIDGE_RCACHE_EN
            r_cv    <= 1'b0;
            r_ca    <= '0;
            r_cd    <= 16'd0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!w_in_range) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
`ifdef SDRAM_BRIDGE_RCACHE_EN
                        end else if (w_hit) begin
                            r_rdata <= r_cd;
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
`endif
                        end else begin
                            r_addr  <= wb_adr;
                            r_sel   <= wb_sel;
                            r_wdata <= wb_i_dat;
                            r_we    <= wb_we;
                            r_cnt   <= 8'd0;
                            r_wreq  <= wb_we;
                            r_rreq  <= !wb_we;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (c_cack || !wb_cyc || w_tmo) begin
                        r_wreq <= 1'b0;
                        r_rreq <= 1'b0;
                    end
`ifdef SDRAM_BRIDGE_RCACHE_EN
                    if (c_cack && r_we)
                        r_cv <= 1'b0;
`endif
                    if (!wb_cyc) begin
                        // Accepted reads must still be drained so the controller's data is not mistaken for the next one
                        if (c_cack && !r_we && !c_read_ready) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (c_cack) begin
                        if (r_we) begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end else if (c_read_ready) begin
                            r_rdata <= c_data_out[15:0];
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
`ifdef SDRAM_BRIDGE_RCACHE_EN
                            r_cv    <= 1'b1;
                            r_ca    <= r_addr;
                            r_cd    <= c_data_out[15:0];
`endif
                        end else begin
                            r_cnt   <= 8'd0;
                            r_state <= S_RWAIT;
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_RWAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (c_read_ready && wb_cyc) begin
                        r_rdata <= c_data_out[15:0];
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
`ifdef SDRAM_BRIDGE_RCACHE_EN
                        r_cv    <= 1'b1;
                        r_ca    <= r_addr;
                        r_cd    <= c_data_out[15:0];
`endif
                    end else if (c_read_ready) begin
                        r_state <= S_IDLE;
                    end else if (!wb_cyc) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_DRAIN;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (c_read_ready || w_tmo)
                        r_state <= S_IDLE;
                end
                S_ACK:   r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_o_dat    = r_rdata;
    assign wb_ack      = r_ack;
    assign wb_err      = r_err;
    assign c_addr      = r_addr;
    assign c_addr_sel  = r_sel;
    assign c_data_in   = r_wdata;
    assign c_read_req  = r_rreq;
    assign c_write_req = r_wreq;

endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_wb_bridge
// Description : Directed self-checking bench for sdram_wb_bridge (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_wb_bridge;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [23:0] adr;
    logic [1:0]  sel;
    logic [15:0] idat;
    logic [15:0] odat;
    logic        ack, err;
    logic [23:0] caddr;
    logic [1:0]  csel;
    logic [15:0] cdin;
    logic        rreq, wreq;
    logic        cack, rrdy;
    logic [31:0] cdout;

    int n_checks = 0;
    int n_errs   = 0;

    sdram_wb_bridge #(
        .ADDR_W  (24),
        .BASE    (24'h100000),
        .END     (24'hffdfff),
        .TIMEOUT (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .wb_cyc       (cyc),
        .wb_stb       (stb),
        .wb_we        (we),
        .wb_adr       (adr),
        .wb_sel       (sel),
        .wb_i_dat     (idat),
        .wb_o_dat     (odat),
        .wb_ack       (ack),
        .wb_err       (err),
        .c_addr       (caddr),
        .c_addr_sel   (csel),
        .c_data_in    (cdin),
        .c_read_req   (rreq),
        .c_write_req  (wreq),
        .c_cack       (cack),
        .c_read_ready (rrdy),
        .c_data_out   (cdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [23:0] a, input logic [15:0] d, input logic [1:0] s);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        idat = d;
        sel  = s;
    endtask

    task automatic stop();
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; idat = 0;
        cack = 0; rrdy = 0; cdout = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack",  32'(ack),   0);
        chk("rst_err",  32'(err),   0);
        chk("rst_rreq", 32'(rreq),  0);
        chk("rst_wreq", 32'(wreq),  0);
        chk("rst_odat", 32'(odat),  0);
        chk("rst_addr", 32'(caddr), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Write 0xBEEF @0x100010, cack in cycle 3
        start(1'b1, 24'h100010, 16'hBEEF, 2'b11);
        tick();
        chk("wr_wreq_c1", 32'(wreq), 1);
        chk("wr_rreq_c1", 32'(rreq), 0);
        chk("wr_cdin",    32'(cdin), 32'hBEEF);
        chk("wr_caddr",   32'(caddr), 32'h100010);
        chk("wr_csel",    32'(csel), 3);
        tick();
        chk("wr_wreq_c2", 32'(wreq), 1);
        tick();
        chk("wr_wreq_c3", 32'(wreq), 1);
        chk("wr_ack_c3",  32'(ack), 0);
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("wr_ack_c4",  32'(ack), 1);
        chk("wr_err_c4",  32'(err), 0);
        chk("wr_wreq_c4", 32'(wreq), 0);
        stop();
        tick();
        chk("wr_ack_c5",  32'(ack), 0);
        chk("wr_odat",    32'(odat), 0);

        // Read 0x100020: cack cycle 2, read_ready cycle 5
        start(1'b0, 24'h100020, 16'h0000, 2'b01);
        tick();
        chk("rd_rreq_c1", 32'(rreq), 1);
        chk("rd_wreq_c1", 32'(wreq), 0);
        chk("rd_csel",    32'(csel), 1);
        tick();
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("rd_rreq_c3", 32'(rreq), 0);
        chk("rd_ack_c3",  32'(ack), 0);
        tick();
        tick();
        rrdy = 1'b1; cdout = 32'hFFFF1234;
        chk("rd_ack_c5",  32'(ack), 0);
        tick();
        rrdy = 1'b0;
        chk("rd_ack_c6",  32'(ack), 1);
        chk("rd_odat_c6", 32'(odat), 32'h1234);
        stop();
        tick();
        chk("rd_ack_c7",  32'(ack), 0);

        // Read 0x100022 with cack and read_ready together
        start(1'b0, 24'h100022, 16'h0000, 2'b11);
        tick();
        cack = 1'b1; rrdy = 1'b1; cdout = 32'h00005678;
        tick();
        cack = 1'b0; rrdy = 1'b0;
        chk("rdq_ack",  32'(ack), 1);
        chk("rdq_odat", 32'(odat), 32'h5678);
        chk("rdq_rreq", 32'(rreq), 0);
        stop();
        tick();

        // Out-of-range below BASE and just above END
        start(1'b0, 24'h002000, 16'h0000, 2'b11);
        tick();
        chk("oor_err",  32'(err), 1);
        chk("oor_rreq", 32'(rreq), 0);
        chk("oor_ack",  32'(ack), 0);
        stop();
        tick();
        chk("oor_err_c2", 32'(err), 0);
        start(1'b1, 24'hFFE000, 16'h0000, 2'b11);
        tick();
        chk("oor_hi_err",  32'(err), 1);
        chk("oor_hi_wreq", 32'(wreq), 0);
        stop();
        tick();

        // Write exactly at BASE with immediate cack: stb-to-ack of 2 cycles
        start(1'b1, 24'h100000, 16'h0F0F, 2'b10);
        tick();
        chk("base_wreq", 32'(wreq), 1);
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("base_ack", 32'(ack), 1);
        stop();
        tick();

        // Read timeout with TIMEOUT=8
        start(1'b0, 24'h100030, 16'h0000, 2'b11);
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_err_c8",  32'(err), 0);
        chk("tmo_rreq_c8", 32'(rreq), 1);
        tick();
        chk("tmo_err_c9",  32'(err), 1);
        chk("tmo_rreq_c9", 32'(rreq), 0);
        stop();
        tick();
        chk("tmo_err_c10", 32'(err), 0);

        // Abort in RWAIT, late read data is drained
        start(1'b0, 24'h100050, 16'h0000, 2'b11);
        tick();
        cack = 1'b1;
        tick();
        cack = 1'b0;
        stop();
        tick();
        chk("abr_ack_c3", 32'(ack), 0);
        chk("abr_rreq",   32'(rreq), 0);
        tick();
        tick();
        tick();
        rrdy = 1'b1; cdout = 32'h0000AAAA;
        tick();
        rrdy = 1'b0;
        chk("abr_ack_c7", 32'(ack), 0);
        chk("abr_err_c7", 32'(err), 0);
        chk("abr_odat",   32'(odat), 32'h5678);
        start(1'b1, 24'h100060, 16'h1111, 2'b11);
        tick();
        chk("abr_nxt_wreq", 32'(wreq), 1);
        chk("abr_nxt_cdin", 32'(cdin), 32'h1111);
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("abr_nxt_ack",  32'(ack), 1);
        chk("abr_nxt_odat", 32'(odat), 32'h5678);
        stop();
        tick();

        // Abort in REQ before cack
        start(1'b0, 24'h100070, 16'h0000, 2'b11);
        tick();
        chk("abq_rreq_c1", 32'(rreq), 1);
        stop();
        tick();
        chk("abq_rreq_c2", 32'(rreq), 0);
        chk("abq_ack_c2",  32'(ack), 0);
        tick();
        chk("abq_err_c3",  32'(err), 0);

        // Read 0x100040 then read it again
        start(1'b0, 24'h100040, 16'h0000, 2'b11);
        tick();
        cack = 1'b1; rrdy = 1'b1; cdout = 32'h00005555;
        tick();
        cack = 1'b0; rrdy = 1'b0;
        chk("c1_ack",  32'(ack), 1);
        chk("c1_odat", 32'(odat), 32'h5555);
        stop();
        tick();
        start(1'b0, 24'h100040, 16'h0000, 2'b11);
        tick();
`ifdef SDRAM_BRIDGE_RCACHE_EN
        chk("c2_hit_ack",  32'(ack), 1);
        chk("c2_hit_odat", 32'(odat), 32'h5555);
        chk("c2_hit_rreq", 32'(rreq), 0);
        stop();
        tick();
        chk("c2_hit_rreq_c2", 32'(rreq), 0);
`else
        chk("c2_miss_rreq", 32'(rreq), 1);
        chk("c2_miss_ack",  32'(ack), 0);
        cack = 1'b1; rrdy = 1'b1; cdout = 32'h00005A5A;
        tick();
        cack = 1'b0; rrdy = 1'b0;
        chk("c2_miss_odat", 32'(odat), 32'h5A5A);
        stop();
        tick();
`endif
        start(1'b1, 24'h100040, 16'h7777, 2'b11);
        tick();
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("c3_wack", 32'(ack), 1);
        stop();
        tick();
        start(1'b0, 24'h100040, 16'h0000, 2'b11);
        tick();
        chk("c4_rreq", 32'(rreq), 1);
        chk("c4_ack",  32'(ack), 0);
        cack = 1'b1; rrdy = 1'b1; cdout = 32'h00006666;
        tick();
        cack = 1'b0; rrdy = 1'b0;
        chk("c4_odat", 32'(odat), 32'h6666);
        stop();
        tick();

        // Async reset in RWAIT
        start(1'b0, 24'h100080, 16'h0000, 2'b10);
        tick();
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("ar_caddr_pre", 32'(caddr), 32'h100080);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rreq",  32'(rreq), 0);
        chk("ar_wreq",  32'(wreq), 0);
        chk("ar_ack",   32'(ack), 0);
        chk("ar_err",   32'(err), 0);
        chk("ar_odat",  32'(odat), 0);
        chk("ar_caddr", 32'(caddr), 0);
        chk("ar_csel",  32'(csel), 0);
        chk("ar_cdin",  32'(cdin), 0);
        stop();
        tick();
        rst_n = 1'b1;
        tick();
        start(1'b0, 24'h100090, 16'h0000, 2'b11);
        tick();
        chk("ar_post_rreq", 32'(rreq), 1);
        cack = 1'b1; rrdy = 1'b1; cdout = 32'h00004321;
        tick();
        cack = 1'b0; rrdy = 1'b0;
        chk("ar_post_ack",  32'(ack), 1);
        chk("ar_post_odat", 32'(odat), 32'h4321);
        stop();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
